// File: rtl/eof_tx.sv
// eof_tx: CAN frame tail transmitter (CRC/ACK delimiters, EOF, intermission) with error-flag generation.
module eof_tx #(
  parameter int EOF_LEN   = 7,
  parameter int IFS_LEN   = 3,
  parameter int FLAG_LEN  = 6,
  parameter int DELIM_LEN = 8
) (
  input  logic SP,
  input  logic reset,
  input  logic Start,
  input  logic RX,
  output logic TX,
  output logic Busy,
  output logic Done,
  output logic ACK_Error,
  output logic Bit_Error
);
  typedef enum logic [2:0] {IDLE, CRC_DEL, ACK_SLOT, ACK_DEL, EOF, IFS, ERR_FLAG, ERR_DELIM} state_t;
  localparam logic [3:0] EOF_LAST   = 4'(EOF_LEN - 1);
  localparam logic [3:0] IFS_LAST   = 4'(IFS_LEN - 1);
  localparam logic [3:0] FLAG_LAST  = 4'(FLAG_LEN - 1);
  localparam logic [3:0] DELIM_LAST = 4'(DELIM_LEN - 1);
  state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  logic tx_n, busy_n, done_n, ack_n, bit_n, err;
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    tx_n    = TX;
    busy_n  = Busy;
    done_n  = 1'b0;
    ack_n   = ACK_Error;
    bit_n   = Bit_Error;
    err     = 1'b0;
    case (state)
      IDLE: begin
        tx_n   = 1'b1;
        busy_n = Start;
        if (Start) begin
          state_n = CRC_DEL;
          ack_n   = 1'b1;
          bit_n   = 1'b1;
          cnt_n   = '0;
        end
      end
      CRC_DEL: begin
        err     = !RX;
        bit_n   = Bit_Error & RX;
        state_n = ACK_SLOT;
      end
      ACK_SLOT: begin
        err     = RX;
        ack_n   = ACK_Error & !RX;
        state_n = ACK_DEL;
      end
      ACK_DEL: begin
        err     = !RX;
        bit_n   = Bit_Error & RX;
        state_n = EOF;
        cnt_n   = '0;
      end
      EOF: begin
        err     = !RX;
        bit_n   = Bit_Error & RX;
        state_n = (cnt == EOF_LAST) ? IFS : EOF;
        cnt_n   = (cnt == EOF_LAST) ? 4'd0 : cnt + 4'd1;
      end
      IFS: begin
        state_n = (cnt == IFS_LAST) ? IDLE : IFS;
        busy_n  = (cnt != IFS_LAST);
        done_n  = (cnt == IFS_LAST);
        cnt_n   = (cnt == IFS_LAST) ? 4'd0 : cnt + 4'd1;
      end
      ERR_FLAG: begin
        state_n = (cnt == FLAG_LAST) ? ERR_DELIM : ERR_FLAG;
        tx_n    = (cnt == FLAG_LAST);
        cnt_n   = (cnt == FLAG_LAST) ? 4'd0 : cnt + 4'd1;
      end
      ERR_DELIM: begin
        state_n = (cnt == DELIM_LAST) ? IDLE : ERR_DELIM;
        tx_n    = 1'b1;
        busy_n  = (cnt != DELIM_LAST);
        cnt_n   = (cnt == DELIM_LAST) ? 4'd0 : cnt + 4'd1;
      end
      default: state_n = IDLE;
    endcase
    // a detected error overrides the normal next step on the same edge
    if (err) begin
      state_n = ERR_FLAG;
      tx_n    = 1'b0;
      cnt_n   = '0;
    end
  end
  always_ff @(posedge SP) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      TX        <= 1'b1;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      ACK_Error <= 1'b1;
      Bit_Error <= 1'b1;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      TX        <= tx_n;
      Busy      <= busy_n;
      Done      <= done_n;
      ACK_Error <= ack_n;
      Bit_Error <= bit_n;
    end
  end
endmodule

// File: tb/tb_eof_tx.sv
// tb_eof_tx: directed and randomized checks of eof_tx against a bit-position model.
module tb_eof_tx;
  localparam int EOF_LEN = 7, IFS_LEN = 3, FLAG_LEN = 6, DELIM_LEN = 8;
  logic SP, reset, Start, RX;
  logic TX, Busy, Done, ACK_Error, Bit_Error;
  int tests = 0, fails = 0;
  bit chk_en = 0;
  int m_pos = 0, m_err = -1;
  logic m_busy = 0, m_tx = 1, m_done = 0, m_ack = 1, m_bit = 1;

  eof_tx #(.EOF_LEN(EOF_LEN), .IFS_LEN(IFS_LEN), .FLAG_LEN(FLAG_LEN), .DELIM_LEN(DELIM_LEN)) dut (
    .SP(SP), .reset(reset), .Start(Start), .RX(RX),
    .TX(TX), .Busy(Busy), .Done(Done), .ACK_Error(ACK_Error), .Bit_Error(Bit_Error)
  );

  initial begin
    SP = 0;
    forever #5 SP = ~SP;
  end

  task automatic chk(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Model tracks bit position since the Start edge and the position of the first error.
  task automatic model_step(input logic st, input logic rx, input logic rs);
    if (rs) begin
      m_busy = 0; m_tx = 1; m_done = 0; m_ack = 1; m_bit = 1;
    end else begin
      m_done = 0;
      if (!m_busy) begin
        if (st) begin
          m_busy = 1; m_pos = 0; m_err = -1; m_ack = 1; m_bit = 1; m_tx = 1;
        end
      end else begin
        m_pos++;
        if (m_err < 0) begin
          if (m_pos == 2 && rx) begin
            m_ack = 0; m_err = m_pos;
          end else if (m_pos != 2 && m_pos <= 3 + EOF_LEN && !rx) begin
            m_bit = 0; m_err = m_pos;
          end else if (m_pos == 3 + EOF_LEN + IFS_LEN) begin
            m_busy = 0; m_done = 1;
          end
          m_tx = (m_err < 0);
        end else begin
          m_tx = (m_pos - m_err >= FLAG_LEN);
          if (m_pos - m_err == FLAG_LEN + DELIM_LEN) m_busy = 0;
        end
      end
    end
  endtask

  task automatic step(input logic st, input logic rx, input logic rs);
    Start = st; RX = rx; reset = rs;
    @(posedge SP);
    model_step(st, rx, rs);
    #1;
  endtask

  always @(negedge SP) if (chk_en) begin
    chk("TX", TX, m_tx);
    chk("Busy", Busy, m_busy);
    chk("Done", Done, m_done);
    chk("ACK_Error", ACK_Error, m_ack);
    chk("Bit_Error", Bit_Error, m_bit);
  end

  initial begin
    Start = 0; RX = 1; reset = 1;
    step(0, 1, 1);
    step(0, 1, 1);
    chk_en = 1;
    chk("rst_tx", TX, 1); chk("rst_busy", Busy, 0); chk("rst_done", Done, 0);
    chk("rst_ack", ACK_Error, 1); chk("rst_bit", Bit_Error, 1);
    for (int e = 0; e <= 13; e++) begin
      step(e == 0, e != 2, 0);
      if (TX !== 1'b1) chk("ok_tx", TX, 1);
      if (e == 12) begin chk("ok_busy12", Busy, 1); chk("ok_done12", Done, 0); end
      if (e == 13) begin
        chk("ok_done13", Done, 1); chk("ok_busy13", Busy, 0);
        chk("ok_ack", ACK_Error, 1); chk("ok_bit", Bit_Error, 1);
      end
    end
    for (int e = 0; e <= 16; e++) begin
      step(e == 0, 1, 0);
      if (e == 1) chk("noack_done_cleared", Done, 0);
      if (e == 2) begin chk("noack_ack2", ACK_Error, 0); chk("noack_tx2", TX, 0); end
      if (e == 7) chk("noack_tx7", TX, 0);
      if (e == 8) chk("noack_tx8", TX, 1);
      if (e == 15) chk("noack_busy15", Busy, 1);
      if (e == 16) begin chk("noack_busy16", Busy, 0); chk("noack_done16", Done, 0); end
    end
    for (int e = 0; e <= 19; e++) begin
      step(e == 0, !(e == 2 || e == 5), 0);
      if (e == 0) chk("eofbit_ack_cleared", ACK_Error, 1);
      if (e == 4) chk("eofbit_bit4", Bit_Error, 1);
      if (e == 5) begin chk("eofbit_bit5", Bit_Error, 0); chk("eofbit_ack5", ACK_Error, 1); chk("eofbit_tx5", TX, 0); end
      if (e == 10) chk("eofbit_tx10", TX, 0);
      if (e == 11) chk("eofbit_tx11", TX, 1);
      if (e == 18) chk("eofbit_busy18", Busy, 1);
      if (e == 19) chk("eofbit_busy19", Busy, 0);
    end
    for (int e = 0; e <= 15; e++) begin
      step(e == 0, e != 1, 0);
      if (e == 1) begin chk("crcdel_bit", Bit_Error, 0); chk("crcdel_ack", ACK_Error, 1); chk("crcdel_tx", TX, 0); end
      if (e == 15) chk("crcdel_idle", Busy, 0);
    end
    for (int e = 0; e <= 27; e++) begin
      step(e == 0 || e == 4 || e == 8 || e == 14, e != 2 && e != 16, 0);
      if (e == 0) chk("restart_bit_cleared", Bit_Error, 1);
      if (e == 12) chk("ign_done12", Done, 0);
      if (e == 13) chk("ign_done13", Done, 1);
      if (e == 14) begin chk("ign_busy14", Busy, 1); chk("ign_ack14", ACK_Error, 1); chk("ign_bit14", Bit_Error, 1); end
      if (e == 27) chk("ign_done27", Done, 1);
    end
    for (int e = 0; e <= 20; e++) begin
      step(e == 0 || e == 7, !(e == 2 || e == 9), e == 6);
      if (e == 6) begin
        chk("rst_eof_tx", TX, 1); chk("rst_eof_busy", Busy, 0); chk("rst_eof_done", Done, 0);
        chk("rst_eof_ack", ACK_Error, 1); chk("rst_eof_bit", Bit_Error, 1);
      end
      if (e == 19) begin chk("rst_eof_done19", Done, 0); chk("rst_eof_busy19", Busy, 1); end
      if (e == 20) chk("rst_eof_done20", Done, 1);
    end
    for (int e = 0; e <= 5; e++) begin
      step(e == 0, 1, e == 4);
      if (e == 3) chk("rst_flag_tx3", TX, 0);
      if (e == 4) begin chk("rst_flag_tx4", TX, 1); chk("rst_flag_ack4", ACK_Error, 1); chk("rst_flag_busy4", Busy, 0); end
    end
    for (int i = 0; i < 4000; i++) begin
      logic st, rx, rs;
      st = ($urandom % 4) == 0;
      rs = ($urandom % 100) == 0;
      if (m_busy && m_err < 0 && m_pos + 1 == 2) rx = ($urandom % 8) == 0;
      else rx = ($urandom % 30) != 0;
      step(st, rx, rs);
    end
    @(negedge SP);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/eof_tx.md
EOF_TX -- requirements
Module: eof_tx

Interface
REQ-001 Parameter EOF_LEN, default 7, number of recessive EOF bits.
REQ-002 Parameter IFS_LEN, default 3, number of recessive intermission bits.
REQ-003 Parameter FLAG_LEN, default 6, number of dominant error-flag bits.
REQ-004 Parameter DELIM_LEN, default 8, number of recessive error-delimiter bits.
REQ-005 SP  input  1  sample-point clock; one rising edge per CAN bit time; sole clock.
REQ-006 reset  input  1  synchronous, active-high reset, sampled on SP rising edge.
REQ-007 Start  input  1  request to transmit frame tail; sampled only in IDLE.
REQ-008 RX  input  1  bus level read back (1 = recessive, 0 = dominant).
REQ-009 TX  output  1  registered bus drive (1 = recessive, 0 = dominant).
REQ-010 Busy  output  1  high while a tail or error sequence is in progress.
REQ-011 Done  output  1  one-cycle pulse on successful tail completion.
REQ-012 ACK_Error  output  1  active-low, latched; no dominant ACK seen.
REQ-013 Bit_Error  output  1  active-low, latched; dominant read back while sending recessive.

Function
REQ-014 States: IDLE, CRC_DEL, ACK_SLOT, ACK_DEL, EOF, IFS, ERR_FLAG, ERR_DELIM; 4-bit counter cnt.
REQ-015 All state, cnt and outputs update only on SP rising edge; all outputs registered.
REQ-016 IDLE: TX=1, Busy=0; Start=1 -> CRC_DEL, Busy=1, ACK_Error=1, Bit_Error=1, TX=1.
REQ-017 Start is ignored in every state other than IDLE.
REQ-018 CRC_DEL: RX=0 -> Bit_Error=0, enter error; else -> ACK_SLOT, TX=1.
REQ-019 ACK_SLOT: TX stays 1; RX=1 -> ACK_Error=0, enter error; RX=0 -> ACK_DEL.
REQ-020 ACK_DEL: RX=0 -> Bit_Error=0, enter error; else -> EOF, cnt=0.
REQ-021 EOF: RX=0 on any edge -> Bit_Error=0, enter error; else cnt==EOF_LEN-1 -> IFS, cnt=0; otherwise cnt+1.
REQ-022 IFS: RX ignored; cnt==IFS_LEN-1 -> IDLE, Busy=0, Done=1; otherwise cnt+1.
REQ-023 Enter error = next state ERR_FLAG, TX=0, cnt=0, same edge the error flag is set.
REQ-024 ERR_FLAG: TX=0, RX ignored; cnt==FLAG_LEN-1 -> ERR_DELIM, TX=1, cnt=0; otherwise cnt+1.
REQ-025 ERR_DELIM: TX=1, RX ignored; cnt==DELIM_LEN-1 -> IDLE, Busy=0, Done stays 0; otherwise cnt+1.
REQ-026 Done is high for exactly one cycle, cleared on the next edge.
REQ-027 ACK_Error and Bit_Error hold until the next accepted Start or reset; at most one is set per sequence.
REQ-028 Successful tail: exactly 1+1+1+EOF_LEN+IFS_LEN recessive bit times (13 at defaults) from Start edge to Done edge.
REQ-029 Error sequence: exactly FLAG_LEN dominant then DELIM_LEN recessive bit times after the error edge.

Reset
REQ-030 reset=1 on an SP edge -> IDLE, cnt=0, TX=1, Busy=0, Done=0, ACK_Error=1, Bit_Error=1.
REQ-031 reset takes priority over Start and over any in-progress sequence, including mid-EOF and mid-ERR_FLAG (TX returns to 1 on the same edge).

Verification
REQ-032 Start at edge 0, RX=1 except RX=0 at edge 2 -> TX=1 throughout, Busy=1 after edges 0-12, Done=1 only after edge 13, both errors stay 1.
REQ-033 Start at edge 0, RX=1 always -> ACK_Error=0 after edge 2, TX=0 after edges 2-7, TX=1 after edges 8-15, Busy=0 after edge 16, Done never 1.
REQ-034 Start at edge 0, ACK dominant at edge 2, RX=0 at edge 5 -> Bit_Error=0 after edge 5, TX=0 after edges 5-10, IDLE after edge 19.
REQ-035 RX=0 at edge 1 (CRC delimiter) -> Bit_Error=0, ACK_Error=1, TX=0 after edge 1.
REQ-036 Start pulses at edges 4 and 8 during a busy tail -> ignored, Done still after edge 13; new Start at edge 14 clears latched errors.
REQ-037 reset at edge 6 during EOF -> TX=1, Busy=0, all flags at reset values after edge 6; next Start restarts a full 13-bit tail.
